game_flow_ctrl: RTL and testbench
=================================

Name: game_flow_ctrl

Overview:
Top-level game sequencer for Flappy Bird. It owns the play/death/game-over state machine and drives the score counter: it holds the counter clear, paces its increments, and freezes it on death. It also keeps a best-score register in 3-digit BCD for the HEX display mux. It sits between the input/collision logic and the score counter.

Parameters:
TICK_FRAMES, 13, frameTick pulses per score increment (scoreTick period)
HOLD_FRAMES, 24, frames spent in DYING before GAME_OVER (death animation)

Ports:
Clock  input  1  system clock
Reset  input  1  synchronous, active-high; clears all state including best score
frameTick  input  1  one-cycle pulse per video frame
start  input  1  debounced start/flap button, level
death  input  1  pipe collision, level
outofbounddeath  input  1  bird left screen, level
hundredsDigit  input  4  current score, BCD, from score counter
tensDigit  input  4  current score, BCD
unitsDigit  input  4  current score, BCD
scoreClear  output  1  holds score counter at 000 while high
scoreTick  output  1  one-cycle increment enable to score counter
gameActive  output  1  high only in PLAY (bird physics and pipe scroll enable)
gameOver  output  1  high only in OVER
newBest  output  1  high in OVER if this run set a new best
bestHundreds  output  4  best score, BCD
bestTens  output  4  best score, BCD
bestUnits  output  4  best score, BCD
state  output  2  current state code (debug/LED)

Behaviour:
- States: IDLE=0, PLAY=1, DYING=2, OVER=3. All outputs are registered.
- Reset values: state IDLE; scoreClear=1; scoreTick=0; gameActive=0; gameOver=0; newBest=0; best=000; divider=0; frame hold counter=0; startPrev=1, so a button held through reset is not an edge.
- startRise = start & ~startPrev. startPrev updates every cycle.
- IDLE: scoreClear=1. On startRise -> PLAY next cycle; scoreClear=0 from that cycle on.
- PLAY: a divider counts frameTick pulses 0..TICK_FRAMES-1.
  - On a frameTick while the divider is at TICK_FRAMES-1: the divider wraps to 0 and scoreTick=1 on the next cycle, for exactly one cycle.
  - dead = death | outofbounddeath. When dead is sampled in cycle n: state=DYING at n+1, divider cleared, and scoreTick=0 at n+1 even if a wrap occurred in cycle n. Death wins over a simultaneous tick.
- DYING: the hold counter increments on each frameTick. At HOLD_FRAMES-1 plus a frameTick -> OVER.
  - Best update happens in the cycle after DYING entry (n+2), once the score is stable.
  - Compare concatenated {hundreds,tens,units} as a 12-bit unsigned value; BCD ordering equals numeric ordering.
  - If current > best: best <= current and newBest flag <= 1. Otherwise both unchanged. Equal is not a new best.
- OVER: gameOver=1; newBest presents the flag. On startRise -> IDLE. The IDLE entry asserts scoreClear (latency 1 cycle) and clears the newBest flag; best is retained.
- startRise in PLAY or DYING is ignored. dead in IDLE, DYING or OVER is ignored.
- Reset asserted in any state takes priority over every transition and returns to reset values on the next edge.
- Counter widths: $clog2 of each parameter, minimum 1 bit. The divider does not advance outside PLAY.

Decomposition:
- Shared package flappy_pkg:
  - game_state_t enum (2-bit codes above)
  - bcd3_t packed struct {hundreds,tens,units} of 4 bits each
  - default constants SCORE_TICK_FRAMES=13 and DEATH_HOLD_FRAMES=24
- One sub-module, tick_divider: parameterised frameTick divider with synchronous clear and enable, producing a registered one-cycle tick. Instantiated for the score divider; the hold counter stays inline.

Test Plan:
- Reset held with start=1, then released -> state=0, scoreClear=1, no PLAY entry until start falls and rises again.
- IDLE, start rise at cycle n -> state=1 at n+1, scoreClear=0. With TICK_FRAMES=13, 26 frameTicks -> exactly 2 scoreTick pulses, each 1 cycle wide, one cycle after the 13th and 26th frameTick.
- In PLAY, death and the 13th frameTick in the same cycle -> state=2 next cycle, scoreTick never asserted, divider reads 0.
- Score 042 at death, best 037 -> best=042 two cycles after death. After HOLD_FRAMES=24 frameTicks: state=3, gameOver=1, newBest=1. Repeat with score 042 -> best stays 042, newBest=0.
- outofbounddeath alone in PLAY -> same DYING path. In OVER, a start rise -> IDLE next cycle with scoreClear=1 and newBest=0.
- Reset asserted mid-DYING -> next cycle state=0, best=000, all outputs at reset values.

Source files
------------

// File: rtl/flappy_pkg.sv
// Shared types and default timing constants for the Flappy Bird game logic.
package flappy_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PLAY  = 2'd1,
        ST_DYING = 2'd2,
        ST_OVER  = 2'd3
    } game_state_t;

    typedef struct packed {
        logic [3:0] hundreds;
        logic [3:0] tens;
        logic [3:0] units;
    } bcd3_t;

    localparam int unsigned SCORE_TICK_FRAMES = 13;
    localparam int unsigned DEATH_HOLD_FRAMES = 24;

endpackage

// File: rtl/tick_divider.sv
// Counts frame pulses and emits a registered one-cycle tick every FRAMES pulses.
module tick_divider #(
    parameter int unsigned FRAMES = 13
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    input  logic frame_tick,
    output logic tick
);

    localparam int unsigned CW = (FRAMES > 1) ? $clog2(FRAMES) : 1;

    logic [CW-1:0] count_q;

    // Clear dominates a coincident wrap, so a cleared cycle never ticks.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            count_q <= '0;
            tick    <= 1'b0;
        end else begin
            tick <= 1'b0;
            if (en && frame_tick) begin
                if (count_q == CW'(FRAMES - 1)) begin
                    count_q <= '0;
                    tick    <= 1'b1;
                end else begin
                    count_q <= count_q + CW'(1);
                end
            end
        end
    end

endmodule

// File: rtl/game_flow_ctrl.sv
// Play/death/game-over sequencer: drives the score counter controls and
// tracks the best score in BCD.
module game_flow_ctrl
    import flappy_pkg::*;
#(
    parameter int unsigned TICK_FRAMES = SCORE_TICK_FRAMES,
    parameter int unsigned HOLD_FRAMES = DEATH_HOLD_FRAMES
) (
    input  logic       Clock,
    input  logic       Reset,
    input  logic       frameTick,
    input  logic       start,
    input  logic       death,
    input  logic       outofbounddeath,
    input  logic [3:0] hundredsDigit,
    input  logic [3:0] tensDigit,
    input  logic [3:0] unitsDigit,
    output logic       scoreClear,
    output logic       scoreTick,
    output logic       gameActive,
    output logic       gameOver,
    output logic       newBest,
    output logic [3:0] bestHundreds,
    output logic [3:0] bestTens,
    output logic [3:0] bestUnits,
    output logic [1:0] state
);

    localparam int unsigned HW = (HOLD_FRAMES > 1) ? $clog2(HOLD_FRAMES) : 1;

    game_state_t   state_q, state_d;
    logic [HW-1:0] hold_q, hold_d;
    bcd3_t         best_q, best_d;
    bcd3_t         cur_score;
    logic          flag_q, flag_d;
    logic          enter_q, enter_d;
    logic          start_prev_q;
    logic          start_rise;
    logic          dead;
    logic          clear_d, active_d, over_d, new_best_d;
    logic          div_clr, div_en;

    assign start_rise = start & ~start_prev_q;
    assign dead       = death | outofbounddeath;
    assign cur_score  = '{hundreds: hundredsDigit, tens: tensDigit, units: unitsDigit};

    // Divider only runs in PLAY; death clears it and suppresses a coincident tick.
    assign div_en  = (state_q == ST_PLAY);
    assign div_clr = (state_q != ST_PLAY) | dead;

    tick_divider #(
        .FRAMES(TICK_FRAMES)
    ) u_score_div (
        .clk       (Clock),
        .rst       (Reset),
        .clr       (div_clr),
        .en        (div_en),
        .frame_tick(frameTick),
        .tick      (scoreTick)
    );

    always_comb begin
        state_d = state_q;
        hold_d  = '0;
        best_d  = best_q;
        flag_d  = flag_q;
        enter_d = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (start_rise) state_d = ST_PLAY;
            end
            ST_PLAY: begin
                if (dead) begin
                    state_d = ST_DYING;
                    enter_d = 1'b1;
                end
            end
            ST_DYING: begin
                hold_d = hold_q;
                // Score is stable one cycle after entry; compare then.
                if (enter_q && (12'(cur_score) > 12'(best_q))) begin
                    best_d = cur_score;
                    flag_d = 1'b1;
                end
                if (frameTick) begin
                    if (hold_q == HW'(HOLD_FRAMES - 1)) begin
                        state_d = ST_OVER;
                        hold_d  = '0;
                    end else begin
                        hold_d = hold_q + HW'(1);
                    end
                end
            end
            ST_OVER: begin
                if (start_rise) begin
                    state_d = ST_IDLE;
                    flag_d  = 1'b0;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        clear_d    = (state_d == ST_IDLE);
        active_d   = (state_d == ST_PLAY);
        over_d     = (state_d == ST_OVER);
        new_best_d = (state_d == ST_OVER) & flag_d;
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q      <= ST_IDLE;
            hold_q       <= '0;
            best_q       <= '0;
            flag_q       <= 1'b0;
            enter_q      <= 1'b0;
            start_prev_q <= 1'b1;
            scoreClear   <= 1'b1;
            gameActive   <= 1'b0;
            gameOver     <= 1'b0;
            newBest      <= 1'b0;
        end else begin
            state_q      <= state_d;
            hold_q       <= hold_d;
            best_q       <= best_d;
            flag_q       <= flag_d;
            enter_q      <= enter_d;
            start_prev_q <= start;
            scoreClear   <= clear_d;
            gameActive   <= active_d;
            gameOver     <= over_d;
            newBest      <= new_best_d;
        end
    end

    assign state        = state_q;
    assign bestHundreds = best_q.hundreds;
    assign bestTens     = best_q.tens;
    assign bestUnits    = best_q.units;

endmodule

// File: tb/tb_game_flow_ctrl.sv
// Directed self-checking bench for game_flow_ctrl with default timing parameters.
module tb_game_flow_ctrl;

    logic       Clock = 1'b0;
    logic       Reset = 1'b1;
    logic       frameTick = 1'b0;
    logic       start = 1'b1;
    logic       death = 1'b0;
    logic       outofbounddeath = 1'b0;
    logic [3:0] hundredsDigit = 4'd0;
    logic [3:0] tensDigit = 4'd0;
    logic [3:0] unitsDigit = 4'd0;
    logic       scoreClear, scoreTick, gameActive, gameOver, newBest;
    logic [3:0] bestHundreds, bestTens, bestUnits;
    logic [1:0] state;
    logic [11:0] best_v;

    int checks = 0;
    int errors = 0;

    assign best_v = {bestHundreds, bestTens, bestUnits};

    always #5 Clock = ~Clock;

    game_flow_ctrl dut (
        .Clock          (Clock),
        .Reset          (Reset),
        .frameTick      (frameTick),
        .start          (start),
        .death          (death),
        .outofbounddeath(outofbounddeath),
        .hundredsDigit  (hundredsDigit),
        .tensDigit      (tensDigit),
        .unitsDigit     (unitsDigit),
        .scoreClear     (scoreClear),
        .scoreTick      (scoreTick),
        .gameActive     (gameActive),
        .gameOver       (gameOver),
        .newBest        (newBest),
        .bestHundreds   (bestHundreds),
        .bestTens       (bestTens),
        .bestUnits      (bestUnits),
        .state          (state)
    );

    task automatic step();
        @(posedge Clock);
        #1;
    endtask

    task automatic test_reset();
        Reset = 1'b1; start = 1'b1;
        repeat (3) step();
        checks++; if (state !== 2'd0) begin errors++; $display("FAIL reset_state got %0d exp 0", state); end
        checks++; if (scoreClear !== 1'b1) begin errors++; $display("FAIL reset_clear got %b exp 1", scoreClear); end
        checks++; if ({scoreTick, gameActive, gameOver, newBest} !== 4'b0000) begin
            errors++; $display("FAIL reset_flags got %b exp 0000", {scoreTick, gameActive, gameOver, newBest}); end
        checks++; if (best_v !== 12'h000) begin errors++; $display("FAIL reset_best got %h exp 000", best_v); end
        Reset = 1'b0;
        repeat (3) step();
        checks++; if (state !== 2'd0) begin errors++; $display("FAIL held_start_no_play got %0d exp 0", state); end
        start = 1'b0; step();
        start = 1'b1; step();
        checks++; if (state !== 2'd1) begin errors++; $display("FAIL play_entry_state got %0d exp 1", state); end
        checks++; if (scoreClear !== 1'b0 || gameActive !== 1'b1) begin
            errors++; $display("FAIL play_entry_outs got clear=%b active=%b exp 0 1", scoreClear, gameActive); end
        start = 1'b0; step();
    endtask

    task automatic test_score_ticks();
        int pulses = 0;
        for (int k = 1; k <= 26; k++) begin
            frameTick = 1'b1; step(); frameTick = 1'b0;
            if (scoreTick === 1'b1) pulses++;
            checks++; if (scoreTick !== ((k % 13) == 0)) begin
                errors++; $display("FAIL tick_after_frame%0d got %b exp %b", k, scoreTick, (k % 13) == 0); end
            step();
            checks++; if (scoreTick !== 1'b0) begin errors++; $display("FAIL tick_width_frame%0d got %b exp 0", k, scoreTick); end
        end
        checks++; if (pulses != 2) begin errors++; $display("FAIL tick_pulse_count got %0d exp 2", pulses); end
    endtask

    task automatic test_death_tick();
        hundredsDigit = 4'd0; tensDigit = 4'd3; unitsDigit = 4'd7;
        repeat (12) begin
            frameTick = 1'b1; step(); frameTick = 1'b0; step();
        end
        checks++; if (dut.u_score_div.count_q !== 4'd12) begin
            errors++; $display("FAIL div_pre_death got %0d exp 12", dut.u_score_div.count_q); end
        frameTick = 1'b1; death = 1'b1; step(); frameTick = 1'b0; death = 1'b0;
        checks++; if (state !== 2'd2) begin errors++; $display("FAIL death_tick_state got %0d exp 2", state); end
        checks++; if (scoreTick !== 1'b0) begin errors++; $display("FAIL death_tick_suppressed got %b exp 0", scoreTick); end
        checks++; if (dut.u_score_div.count_q !== 4'd0) begin
            errors++; $display("FAIL div_cleared got %0d exp 0", dut.u_score_div.count_q); end
        checks++; if (best_v !== 12'h000) begin errors++; $display("FAIL best_not_yet got %h exp 000", best_v); end
        step();
        checks++; if (scoreTick !== 1'b0) begin errors++; $display("FAIL death_tick_late got %b exp 0", scoreTick); end
        checks++; if (best_v !== 12'h037) begin errors++; $display("FAIL best_037 got %h exp 037", best_v); end
        repeat (24) begin
            frameTick = 1'b1; step(); frameTick = 1'b0; step();
        end
        checks++; if (state !== 2'd3 || gameOver !== 1'b1 || newBest !== 1'b1) begin
            errors++; $display("FAIL over_first got st=%0d go=%b nb=%b exp 3 1 1", state, gameOver, newBest); end
        start = 1'b1; step();
        checks++; if (state !== 2'd0 || scoreClear !== 1'b1 || newBest !== 1'b0 || gameOver !== 1'b0) begin
            errors++; $display("FAIL over_to_idle got st=%0d clr=%b nb=%b go=%b exp 0 1 0 0", state, scoreClear, newBest, gameOver); end
        checks++; if (best_v !== 12'h037) begin errors++; $display("FAIL best_retained got %h exp 037", best_v); end
        start = 1'b0; step();
    endtask

    task automatic test_new_best();
        start = 1'b1; step(); start = 1'b0; step();
        hundredsDigit = 4'd0; tensDigit = 4'd4; unitsDigit = 4'd2;
        death = 1'b1; step(); death = 1'b0;
        checks++; if (best_v !== 12'h037) begin errors++; $display("FAIL best_hold_n1 got %h exp 037", best_v); end
        step();
        checks++; if (best_v !== 12'h042) begin errors++; $display("FAIL best_042 got %h exp 042", best_v); end
        for (int k = 1; k <= 24; k++) begin
            frameTick = 1'b1; step(); frameTick = 1'b0;
            if (k == 23) begin
                checks++; if (state !== 2'd2) begin errors++; $display("FAIL hold_23 got %0d exp 2", state); end
            end
            step();
        end
        checks++; if (state !== 2'd3 || gameOver !== 1'b1 || newBest !== 1'b1) begin
            errors++; $display("FAIL over_new_best got st=%0d go=%b nb=%b exp 3 1 1", state, gameOver, newBest); end
        start = 1'b1; step(); start = 1'b0; step();
    endtask

    task automatic test_equal_best();
        start = 1'b1; step(); start = 1'b0; step();
        checks++; if (state !== 2'd1) begin errors++; $display("FAIL replay_state got %0d exp 1", state); end
        outofbounddeath = 1'b1; step(); outofbounddeath = 1'b0;
        checks++; if (state !== 2'd2) begin errors++; $display("FAIL oob_dying got %0d exp 2", state); end
        start_rise_in_dying();
        repeat (24) begin
            frameTick = 1'b1; step(); frameTick = 1'b0; step();
        end
        checks++; if (best_v !== 12'h042) begin errors++; $display("FAIL best_equal got %h exp 042", best_v); end
        checks++; if (state !== 2'd3 || gameOver !== 1'b1 || newBest !== 1'b0) begin
            errors++; $display("FAIL over_equal got st=%0d go=%b nb=%b exp 3 1 0", state, gameOver, newBest); end
        start = 1'b1; step(); start = 1'b0; step();
        death = 1'b1; step(); death = 1'b0; step();
        checks++; if (state !== 2'd0 || scoreClear !== 1'b1) begin
            errors++; $display("FAIL idle_ignores_death got st=%0d clr=%b exp 0 1", state, scoreClear); end
    endtask

    task automatic start_rise_in_dying();
        start = 1'b1; step(); start = 1'b0; step();
        checks++; if (state !== 2'd2) begin errors++; $display("FAIL dying_ignores_start got %0d exp 2", state); end
    endtask

    task automatic test_reset_mid_dying();
        start = 1'b1; step(); start = 1'b0; step();
        death = 1'b1; step(); death = 1'b0;
        repeat (3) begin
            frameTick = 1'b1; step(); frameTick = 1'b0; step();
        end
        checks++; if (state !== 2'd2) begin errors++; $display("FAIL pre_reset_dying got %0d exp 2", state); end
        Reset = 1'b1; step();
        checks++; if (state !== 2'd0 || best_v !== 12'h000) begin
            errors++; $display("FAIL mid_reset got st=%0d best=%h exp 0 000", state, best_v); end
        checks++; if ({scoreClear, scoreTick, gameActive, gameOver, newBest} !== 5'b10000) begin
            errors++; $display("FAIL mid_reset_outs got %b exp 10000", {scoreClear, scoreTick, gameActive, gameOver, newBest}); end
        Reset = 1'b0; step();
    endtask

    initial begin
        test_reset();
        test_score_ticks();
        test_death_tick();
        test_new_best();
        test_equal_best();
        test_reset_mid_dying();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
